mem_bus_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single memory controller port on the `main_bus`. It sits between the instruction-fetch unit (IF) and the execute unit (EX), and serialises their accesses. For each access it presents one fully qualified read or write to the memory controller and holds it until `mem_finished`. It then returns read data and a one-cycle acknowledge to the winning requester.

---
 rtl/mem_bus_arbiter_if.sv | 45 ++++
 rtl/mem_bus_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Requester and memory-controller signals of the IF/EX memory arbiter.
// master: the arbiter side; slave: requesters plus controller side.
`ifndef INSTRUCTION_FETCH
`define INSTRUCTION_FETCH 1'b0
`endif
`ifndef DATA_READ
`define DATA_READ 1'b1
`endif

interface mem_bus_arbiter_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 12
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_ack;
    logic [DATA_WIDTH-1:0] if_rdata;
    logic                  ex_req;
    logic                  ex_we;
    logic [ADDR_WIDTH-1:0] ex_addr;
    logic [DATA_WIDTH-1:0] ex_wdata;
    logic                  ex_ack;
    logic [DATA_WIDTH-1:0] ex_rdata;
    logic                  mem_read_enable;
    logic                  mem_write_enable;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_write_data;
    logic                  mem_read_type;
    logic [DATA_WIDTH-1:0] mem_read_data;
    logic                  mem_finished;

    modport master (
        input  if_req, if_addr, ex_req, ex_we, ex_addr, ex_wdata,
        input  mem_read_data, mem_finished,
        output if_ack, if_rdata, ex_ack, ex_rdata,
        output mem_read_enable, mem_write_enable, mem_address, mem_write_data, mem_read_type
    );

    modport slave (
        output if_req, if_addr, ex_req, ex_we, ex_addr, ex_wdata,
        output mem_read_data, mem_finished,
        input  if_ack, if_rdata, ex_ack, ex_rdata,
        input  mem_read_enable, mem_write_enable, mem_address, mem_write_data, mem_read_type
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Serialises IF/EX accesses onto one memory controller port: grant, hold until mem_finished, 1-cycle ack.
// Fixed EX-over-IF priority by default; defining MEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration.
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH    = 12,
    parameter int DATA_WIDTH    = 12,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_bus_arbiter_if.master bus
);
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {SETTLE, IDLE, BUSY, RESP} state_t;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      settle_cnt;
    logic                  any_req;
    logic                  grant_ex;
    logic                  grant;
    logic                  win_ex;
    logic                  we_q;
    logic                  read_type_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] if_rdata_q;
    logic [DATA_WIDTH-1:0] ex_rdata_q;

    assign any_req = bus.if_req | bus.ex_req;
    assign grant   = (state == IDLE) && any_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // 1 = EX was granted last; reset to "IF last" so EX wins the first contention
    logic last_ex;

    assign grant_ex = bus.ex_req & (~bus.if_req | ~last_ex);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_ex <= 1'b0;
        end else if (grant) begin
            last_ex <= grant_ex;
        end
    end
`else
    assign grant_ex = bus.ex_req;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SETTLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SETTLE: if (settle_cnt <= CNT_W'(1)) state_nxt = IDLE;
            IDLE:   if (any_req) state_nxt = BUSY;
            BUSY:   if (bus.mem_finished) state_nxt = RESP;
            RESP:   state_nxt = IDLE;
            default: state_nxt = SETTLE;
        endcase
    end

    // Counter reloads only on reset; it covers a controller transaction still in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= CNT_W'(SETTLE_CYCLES);
        end else if (state == SETTLE && settle_cnt != '0) begin
            settle_cnt <= settle_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_ex      <= 1'b0;
            we_q        <= 1'b0;
            read_type_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            if_rdata_q  <= '0;
            ex_rdata_q  <= '0;
        end else begin
            if (grant) begin
                win_ex      <= grant_ex;
                we_q        <= grant_ex & bus.ex_we;
                read_type_q <= grant_ex ? `DATA_READ : `INSTRUCTION_FETCH;
                addr_q      <= grant_ex ? bus.ex_addr : bus.if_addr;
                wdata_q     <= grant_ex ? bus.ex_wdata : '0;
            end
            if (state == BUSY && bus.mem_finished) begin
                if (win_ex) begin
                    ex_rdata_q <= bus.mem_read_data;
                end else begin
                    if_rdata_q <= bus.mem_read_data;
                end
            end
        end
    end

    // Enables follow the state, so they drop the instant reset is asserted
    always_comb begin
        bus.mem_read_enable  = 1'b0;
        bus.mem_write_enable = 1'b0;
        bus.if_ack           = 1'b0;
        bus.ex_ack           = 1'b0;
        if (state == BUSY) begin
            bus.mem_read_enable  = ~we_q;
            bus.mem_write_enable = we_q;
        end
        if (state == RESP) begin
            bus.if_ack = ~win_ex;
            bus.ex_ack = win_ex;
        end
    end

    assign bus.mem_address    = addr_q;
    assign bus.mem_write_data = wdata_q;
    assign bus.mem_read_type  = read_type_q;
    assign bus.if_rdata       = if_rdata_q;
    assign bus.ex_rdata       = ex_rdata_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: memory-controller model plus ack scoreboard, directed steps.
module tb_mem_bus_arbiter;
    localparam int AW = 12;
    localparam int DW = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SETTLE_CYCLES(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    typedef struct packed {
        logic          ex;
        logic          chk;
        logic [DW-1:0] data;
    } exp_t;

    exp_t    sb_q[$];
    int      grant_q[$];
    int      checks = 0;
    int      errors = 0;
    int      cyc = 0;
    int      last_grant_cyc = 0;
    logic    last_grant_type = 1'b0;
    logic [AW-1:0] last_grant_addr = '0;
    logic    prev_en = 1'b0;

    function automatic exp_t mk(input logic ex, input logic chk, input logic [DW-1:0] data);
        exp_t e;
        e.ex = ex;
        e.chk = chk;
        e.data = data;
        return e;
    endfunction

    function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
        return a ^ 12'o5252;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory controller: IDLE -> READ/WRITE -> DONE (mem_finished) -> IDLE
    logic [DW-1:0] mem [4096];
    int            cst = 0;
    logic          preloaded = 1'b0;
    logic          c_we = 1'b0;
    logic [AW-1:0] c_addr = '0;
    logic [DW-1:0] c_wdata = '0;
    int            rd_cnt = 0;
    int            wr_cnt = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!preloaded) begin
            for (int i = 0; i < 4096; i++) mem[i] <= pattern(12'(i));
            mem[12'o200]      <= 12'o7402;
            preloaded         <= 1'b1;
            bus.mem_finished  <= 1'b0;
            bus.mem_read_data <= '0;
        end else begin
            case (cst)
                0: if (bus.mem_read_enable || bus.mem_write_enable) begin
                    cst     <= 1;
                    c_we    <= bus.mem_write_enable;
                    c_addr  <= bus.mem_address;
                    c_wdata <= bus.mem_write_data;
                    if (bus.mem_write_enable) wr_cnt <= wr_cnt + 1;
                    else rd_cnt <= rd_cnt + 1;
                end
                1: begin
                    cst <= 2;
                    if (c_we) mem[c_addr] <= c_wdata;
                    bus.mem_read_data <= mem[c_addr];
                    bus.mem_finished  <= 1'b1;
                end
                default: begin
                    cst <= 0;
                    bus.mem_finished <= 1'b0;
                end
            endcase
        end
    end

    // Grant tracker and ack scoreboard
    always @(negedge clk) begin : mon
        logic en;
        exp_t e;
        en = bus.mem_read_enable | bus.mem_write_enable;
        if (en && !prev_en) begin
            grant_q.push_back(cyc);
            last_grant_cyc  = cyc;
            last_grant_type = bus.mem_read_type;
            last_grant_addr = bus.mem_address;
        end
        prev_en = en;
        if (bus.if_ack || bus.ex_ack) begin
            check("ack_exclusive", 32'(bus.if_ack & bus.ex_ack), 32'd0);
            check("ack_latency", 32'(cyc - last_grant_cyc), 32'd3);
            if (sb_q.size() == 0) begin
                check("unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("ack_who", 32'(bus.ex_ack), 32'(e.ex));
                if (e.chk) check("ack_rdata", 32'(e.ex ? bus.ex_rdata : bus.if_rdata), 32'(e.data));
            end
        end
    end

    task automatic wait_ack(input logic ex, input string tag);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = ex ? bus.ex_ack : bus.if_ack;
        end
        check($sformatf("%s_ack_seen", tag), 32'(got), 32'd1);
    endtask

    initial begin : main
        logic got;
        int   rd0;
        int   wr0;
        bus.if_req = 1'b1;
        bus.if_addr = 12'o200;
        bus.ex_req = 1'b0;
        bus.ex_we = 1'b0;
        bus.ex_addr = '0;
        bus.ex_wdata = '0;
        rst_n = 1'b0;

        // Reset and settle with IF already requesting
        repeat (3) @(negedge clk);
        check("rst_read_enable", 32'(bus.mem_read_enable), 32'd0);
        check("rst_write_enable", 32'(bus.mem_write_enable), 32'd0);
        check("rst_address", 32'(bus.mem_address), 32'd0);
        check("rst_write_data", 32'(bus.mem_write_data), 32'd0);
        check("rst_read_type", 32'(bus.mem_read_type), 32'd0);
        check("rst_if_ack", 32'(bus.if_ack), 32'd0);
        check("rst_ex_ack", 32'(bus.ex_ack), 32'd0);
        check("rst_if_rdata", 32'(bus.if_rdata), 32'd0);
        check("rst_ex_rdata", 32'(bus.ex_rdata), 32'd0);
        sb_q.push_back(mk(1'b0, 1'b1, 12'o7402));
        rd0 = rd_cnt;
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check($sformatf("settle_read_enable_%0d", i), 32'(bus.mem_read_enable), 32'd0);
        end

        // IF read of 0200
        wait_ack(1'b0, "if_read");
        bus.if_req = 1'b0;
        check("if_read_type", 32'(last_grant_type), 32'(`INSTRUCTION_FETCH));
        check("if_read_addr", 32'(last_grant_addr), 32'(12'o200));
        repeat (3) @(negedge clk);
        check("if_read_count", 32'(rd_cnt - rd0), 32'd1);

        // EX write 0050 to 0017, then read it back
        sb_q.push_back(mk(1'b1, 1'b0, '0));
        wr0 = wr_cnt;
        bus.ex_req = 1'b1;
        bus.ex_we = 1'b1;
        bus.ex_addr = 12'o17;
        bus.ex_wdata = 12'o50;
        wait_ack(1'b1, "ex_write");
        bus.ex_req = 1'b0;
        bus.ex_we = 1'b0;
        check("ex_write_addr", 32'(last_grant_addr), 32'(12'o17));
        repeat (2) @(negedge clk);
        check("ex_write_count", 32'(wr_cnt - wr0), 32'd1);
        sb_q.push_back(mk(1'b1, 1'b1, 12'o50));
        bus.ex_req = 1'b1;
        wait_ack(1'b1, "ex_read");
        bus.ex_req = 1'b0;
        check("ex_read_type", 32'(last_grant_type), 32'(`DATA_READ));
        repeat (2) @(negedge clk);

        // Reset one cycle after grant; stale DONE lands in SETTLE
        rd0 = rd_cnt;
        bus.if_req = 1'b1;
        bus.if_addr = 12'o200;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = bus.mem_read_enable;
        end
        check("midbusy_grant_seen", 32'(got), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        bus.if_req = 1'b0;
        #1;
        check("midbusy_read_enable", 32'(bus.mem_read_enable), 32'd0);
        check("midbusy_address", 32'(bus.mem_address), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        sb_q.push_back(mk(1'b0, 1'b1, pattern(12'o1)));
        bus.if_addr = 12'o1;
        bus.if_req = 1'b1;
        wait_ack(1'b0, "post_reset_if");
        bus.if_req = 1'b0;
        check("post_reset_addr", 32'(last_grant_addr), 32'(12'o1));
        repeat (2) @(negedge clk);
        check("post_reset_read_count", 32'(rd_cnt - rd0), 32'd2);

        // Contention: both requesters held
        grant_q.delete();
        bus.ex_addr = 12'o300;
        bus.ex_we = 1'b0;
        bus.if_addr = 12'o200;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        sb_q.push_back(mk(1'b1, 1'b1, pattern(12'o300)));
        sb_q.push_back(mk(1'b0, 1'b1, 12'o7402));
        sb_q.push_back(mk(1'b1, 1'b1, pattern(12'o300)));
        sb_q.push_back(mk(1'b0, 1'b1, 12'o7402));
        bus.ex_req = 1'b1;
        bus.if_req = 1'b1;
        wait_ack(1'b1, "rr_ex0");
        wait_ack(1'b0, "rr_if0");
        wait_ack(1'b1, "rr_ex1");
        wait_ack(1'b0, "rr_if1");
        bus.ex_req = 1'b0;
        bus.if_req = 1'b0;
`else
        for (int i = 0; i < 3; i++) sb_q.push_back(mk(1'b1, 1'b1, pattern(12'o300)));
        sb_q.push_back(mk(1'b0, 1'b1, 12'o7402));
        bus.ex_req = 1'b1;
        bus.if_req = 1'b1;
        for (int i = 0; i < 3; i++) wait_ack(1'b1, $sformatf("fp_ex%0d", i));
        bus.ex_req = 1'b0;
        wait_ack(1'b0, "fp_if");
        bus.if_req = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("contention_grants", 32'(grant_q.size()), 32'd4);
        for (int i = 1; i < 4 && i < grant_q.size(); i++)
            check($sformatf("grant_spacing_%0d", i), 32'(grant_q[i] - grant_q[i-1]), 32'd5);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
